// File: rtl/xc_aes_pkg.sv
// Shared AES GF(2^8) helpers and MixColumns coefficient sets.
package xc_aes_pkg;

    // Coefficient k (nibble [4k+3:4k]) multiplies input row (r+k) mod 4 for output row r.
    localparam logic [15:0] MIX_ENC_COEF = 16'h1132;  // k0=2, k1=3, k2=1, k3=1
    localparam logic [15:0] MIX_DEC_COEF = 16'h9DBE;  // k0=E, k1=B, k2=D, k3=9

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aesmix_state_t;

    // Multiply by x in GF(2^8) mod 0x11B.
    function automatic logic [7:0] xt2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using repeated doubling.
    function automatic logic [7:0] xtX(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xt2(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/xc_aesmix_col.sv
// Combinational single-column MixColumns / InvMixColumns.
module xc_aesmix_col
    import xc_aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_enc,
    output logic [31:0] o_col
);

    logic [15:0] w_coef;

    assign w_coef = i_enc ? MIX_ENC_COEF : MIX_DEC_COEF;

    // Each output row is the XOR of all input rows scaled by the rotated coefficient.
    always_comb begin
        o_col = 32'h0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                o_col[8*r +: 8] = o_col[8*r +: 8]
                                ^ xtX(i_col[8*j +: 8], w_coef[4*((j - r + 4) % 4) +: 4]);
            end
        end
    end

endmodule

// File: rtl/xc_aesmix_iter.sv
// Iterative 128-bit AES (Inv)MixColumns engine, LANES columns per cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for valid; captures operand, enc and clears column
// BUSY    | transforms LANES columns per cycle; valid low aborts
// DONE    | ready pulses for one cycle, then back to IDLE
module xc_aesmix_iter
    import xc_aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic         enc,
    input  logic [127:0] state,
    output logic         ready,
    output logic [127:0] result
);

    localparam int NCYC = 4 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NCYC - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("xc_aesmix_iter: LANES must be 1, 2 or 4");
        end
    endgenerate

    aesmix_state_t r_fsm;
    logic [CW-1:0] r_col;
    logic [127:0]  r_op;
    logic          r_enc;
    logic [127:0]  r_res;
    logic          r_ready;

    logic [31:0]   w_lane_in  [LANES];
    logic [31:0]   w_lane_out [LANES];

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lane_in[l] = r_op[32*(int'(r_col)*LANES + l) +: 32];

            xc_aesmix_col u_col (
                .i_col (w_lane_in[l]),
                .i_enc (r_enc),
                .o_col (w_lane_out[l])
            );
        end
    endgenerate

    // Control FSM with operand capture, column stepping and result write-back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm   <= ST_IDLE;
            r_col   <= '0;
            r_op    <= 128'h0;
            r_enc   <= 1'b0;
            r_res   <= 128'h0;
            r_ready <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (valid) begin
                        r_op  <= state;
                        r_enc <= enc;
                        r_col <= '0;
                        r_fsm <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!valid) begin
                        r_fsm <= ST_IDLE;
                    end else begin
                        for (int l = 0; l < LANES; l++) begin
                            r_res[32*(int'(r_col)*LANES + l) +: 32] <= w_lane_out[l];
                        end
                        if (r_col == LAST_COL) begin
                            r_fsm   <= ST_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b0;
                    r_fsm   <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_fsm   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign result = r_res;

endmodule

// File: tb/tb_xc_aesmix_iter.sv
// Bench for xc_aesmix_iter: three instances (LANES 1, 2, 4) checked against a GF(2^8) model.
module tb_xc_aesmix_iter;

    localparam logic [127:0] FIPS_IN  = {4{32'h455313db}};
    localparam logic [127:0] FIPS_OUT = {4{32'hbca14d8e}};
    localparam logic [127:0] MIX_IN   = {32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'h5c220af2};
    localparam logic [127:0] MIX_OUT  = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f};

    logic         clk = 1'b0;
    logic [2:0]   rstn_v = 3'b111;
    logic [2:0]   valid_v = 3'b000;
    logic [2:0]   enc_v = 3'b000;
    logic [127:0] state_v [3];
    logic         ready_v [3];
    logic [127:0] result_v [3];

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    int           exp_at  [3] = '{-1, -1, -1};
    logic [127:0] exp_res [3];
    logic [127:0] hold    [3] = '{128'h0, 128'h0, 128'h0};
    bit           known   [3] = '{1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    xc_aesmix_iter #(.LANES(1)) u_dut1 (
        .clock(clk), .reset(rstn_v[0]), .valid(valid_v[0]), .enc(enc_v[0]),
        .state(state_v[0]), .ready(ready_v[0]), .result(result_v[0]));
    xc_aesmix_iter #(.LANES(2)) u_dut2 (
        .clock(clk), .reset(rstn_v[1]), .valid(valid_v[1]), .enc(enc_v[1]),
        .state(state_v[1]), .ready(ready_v[1]), .result(result_v[1]));
    xc_aesmix_iter #(.LANES(4)) u_dut4 (
        .clock(clk), .reset(rstn_v[2]), .valid(valid_v[2]), .enc(enc_v[2]),
        .state(state_v[2]), .ready(ready_v[2]), .result(result_v[2]));

    function automatic int ncyc(int d);
        case (d)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    // Schoolbook polynomial product then reduction modulo 0x11B.
    function automatic logic [7:0] gm(logic [7:0] a, int b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix(logic [127:0] s, logic en);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            if (en) begin
                o[32*c      +: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                o[32*c + 8  +: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                o[32*c + 16 +: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                o[32*c + 24 +: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
            end else begin
                o[32*c      +: 8] = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
                o[32*c + 8  +: 8] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
                o[32*c + 16 +: 8] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
                o[32*c + 24 +: 8] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
            end
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Record that a request is captured in cycle c0.
    task automatic model_start(int d, logic [127:0] st, logic en, int c0);
        exp_at[d]  = c0 + ncyc(d) + 1;
        exp_res[d] = mix(st, en);
        known[d]   = 1'b0;
    endtask

    // Per-cycle compare of ready and result against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (cyc == exp_at[d]) begin
                chk($sformatf("ready_pulse[%0d]@%0d", d, cyc), 128'(ready_v[d]), 128'd1);
                chk($sformatf("result[%0d]@%0d", d, cyc), result_v[d], exp_res[d]);
                hold[d]  = exp_res[d];
                known[d] = 1'b1;
            end else begin
                chk($sformatf("ready_low[%0d]@%0d", d, cyc), 128'(ready_v[d]), 128'd0);
                if (known[d])
                    chk($sformatf("result_hold[%0d]@%0d", d, cyc), result_v[d], hold[d]);
            end
        end
    end

    task automatic wait_ready(int d);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ready_v[d]) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("ready_timeout[%0d]", d), 128'(seen), 128'd1);
    endtask

    task automatic run_txn(int d, logic [127:0] st, logic en, output logic [127:0] res);
        int c0;
        @(negedge clk);
        #1;
        state_v[d] = st;
        enc_v[d]   = en;
        valid_v[d] = 1'b1;
        c0 = cyc;
        model_start(d, st, en, c0);
        wait_ready(d);
        chk($sformatf("latency[%0d]", d), 128'(cyc - c0), 128'(ncyc(d) + 1));
        res = result_v[d];
        #1;
        valid_v[d] = 1'b0;
    endtask

    task automatic b2b(int d, logic [127:0] a, logic [127:0] b, logic [127:0] exp_b);
        int r1;
        @(negedge clk);
        #1;
        state_v[d] = a;
        enc_v[d]   = 1'b1;
        valid_v[d] = 1'b1;
        model_start(d, a, 1'b1, cyc);
        wait_ready(d);
        r1 = cyc;
        #1;
        state_v[d] = b;
        model_start(d, b, 1'b1, cyc + 1);
        wait_ready(d);
        chk($sformatf("b2b_gap[%0d]", d), 128'(cyc - r1), 128'(ncyc(d) + 2));
        chk($sformatf("b2b_res[%0d]", d), result_v[d], exp_b);
        #1;
        valid_v[d] = 1'b0;
    endtask

    task automatic abort_then_run(int d);
        logic [127:0] r;
        @(negedge clk);
        #1;
        state_v[d] = MIX_IN;
        enc_v[d]   = 1'b1;
        valid_v[d] = 1'b1;
        exp_at[d]  = -1;
        known[d]   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        valid_v[d] = 1'b0;
        repeat (6) @(negedge clk);
        run_txn(d, FIPS_IN, 1'b1, r);
        chk($sformatf("after_abort[%0d]", d), r, FIPS_OUT);
    endtask

    task automatic reset_mid(int d);
        logic [127:0] r;
        @(negedge clk);
        #1;
        state_v[d] = MIX_IN;
        enc_v[d]   = 1'b1;
        valid_v[d] = 1'b1;
        model_start(d, MIX_IN, 1'b1, cyc);
        @(negedge clk);
        #2;
        rstn_v[d] = 1'b0;
        exp_at[d] = -1;
        known[d]  = 1'b1;
        hold[d]   = 128'h0;
        #1;
        chk($sformatf("rst_ready[%0d]", d), 128'(ready_v[d]), 128'd0);
        chk($sformatf("rst_result[%0d]", d), result_v[d], 128'h0);
        valid_v[d] = 1'b0;
        @(negedge clk);
        #1;
        rstn_v[d] = 1'b1;
        run_txn(d, FIPS_IN, 1'b1, r);
        chk($sformatf("after_rst[%0d]", d), r, FIPS_OUT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r, r2, x;
        for (int d = 0; d < 3; d++) state_v[d] = 128'h0;
        #1;
        rstn_v = 3'b000;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready[%0d]", d), 128'(ready_v[d]), 128'd0);
            chk($sformatf("reset_result[%0d]", d), result_v[d], 128'h0);
        end
        #1;
        rstn_v = 3'b111;

        chk("model_fips", mix(FIPS_IN, 1'b1), FIPS_OUT);
        chk("model_mixed", mix(MIX_IN, 1'b1), MIX_OUT);
        chk("model_inv", mix(MIX_OUT, 1'b0), MIX_IN);

        run_txn(0, FIPS_IN, 1'b1, r);
        chk("fips_l1", r, FIPS_OUT);
        for (int d = 0; d < 3; d++) begin
            run_txn(d, MIX_IN, 1'b1, r);
            chk($sformatf("mixed_enc[%0d]", d), r, MIX_OUT);
            run_txn(d, r, 1'b0, r2);
            chk($sformatf("mixed_dec[%0d]", d), r2, MIX_IN);
            run_txn(d, FIPS_OUT, 1'b0, r2);
            chk($sformatf("fips_dec[%0d]", d), r2, FIPS_IN);
        end

        abort_then_run(0);
        for (int d = 0; d < 3; d++) reset_mid(d);
        for (int d = 0; d < 3; d++) b2b(d, MIX_IN, FIPS_IN, FIPS_OUT);

        for (int d = 0; d < 3; d++) begin
            int n;
            n = (d == 2) ? 1000 : 100;
            for (int i = 0; i < n; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                run_txn(d, x, 1'b1, r);
                run_txn(d, r, 1'b0, r2);
                chk($sformatf("roundtrip[%0d]", d), r2, x);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
